// File: rtl/pc_gen_pkg.sv
// Shared constants and helpers for the fetch-address generator and its BTB.
// Counter encodings and the redirect-index width live here so both blocks agree.
package pc_gen_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    function automatic int redir_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : (c + 2'b01);
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : (c - 2'b01);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the registered fetch PC; updates land on the clock edge.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

    logic                  valid_r  [BTB_ENTRIES];
    logic [TAG_W-1:0]      tag_r    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] target_r [BTB_ENTRIES];
    logic [1:0]            ctr_r    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_hit_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic             up_hit_s;
    logic             unused_s;

    // Instructions are word aligned, so the low two address bits never select anything.
    assign unused_s = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx_s = lookup_pc[IDX_W+1:2];
    assign lk_tag_s = lookup_pc[ADDR_WIDTH-1:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    assign lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

    // Lookup reads pre-update state, so a same-cycle update is seen only next cycle.
    assign pred_taken  = lk_hit_s & ctr_r[lk_idx_s][1];
    assign pred_target = target_r[lk_idx_s];

    // Entry storage: clear on reset, then train from resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDR_WIDTH{1'b0}};
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                target_r[up_idx_s] <= upd_target;
                if (up_hit_s) begin
                    ctr_r[up_idx_s] <= ctr_inc(ctr_r[up_idx_s]);
                end else begin
                    valid_r[up_idx_s] <= 1'b1;
                    tag_r[up_idx_s]   <= up_tag_s;
                    ctr_r[up_idx_s]   <= CTR_WT;
                end
            end else if (up_hit_s) begin
                ctr_r[up_idx_s] <= ctr_dec(ctr_r[up_idx_s]);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: PC register, prioritised redirect arbitration with a
// single pending slot, valid/ready fetch handshake and BTB-driven prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned                ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = {ADDR_WIDTH{1'b0}},
    parameter int                         NUM_REDIRECT = 2,
    parameter int unsigned                BTB_ENTRIES  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [NUM_REDIRECT-1:0]            redir_valid_i,
    input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redir_target_i,
    output logic [ADDR_WIDTH-1:0]              pc_o,
    output logic                               pc_valid_o,
    input  logic                               pc_ready_i,
    output logic                               pred_taken_o,
    output logic [ADDR_WIDTH-1:0]              pred_target_o,
    input  logic                               btb_upd_valid_i,
    input  logic [ADDR_WIDTH-1:0]              btb_upd_pc_i,
    input  logic [ADDR_WIDTH-1:0]              btb_upd_target_i,
    input  logic                               btb_upd_taken_i
);

    localparam int                    RIW    = redir_idx_width(NUM_REDIRECT);
    localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(INST_BYTES);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic                  pc_valid_r;
    logic                  pend_valid_r;
    logic [RIW-1:0]        pend_idx_r;
    logic [ADDR_WIDTH-1:0] pend_target_r;

    logic                  adv_s;
    logic                  cur_valid_s;
    logic [RIW-1:0]        cur_idx_s;
    logic [ADDR_WIDTH-1:0] cur_target_s;
    logic                  pend_wins_s;
    logic                  win_valid_s;
    logic [RIW-1:0]        win_idx_s;
    logic [ADDR_WIDTH-1:0] win_target_s;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic                  pred_taken_s;
    logic [ADDR_WIDTH-1:0] pred_target_s;

    pc_btb #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_r),
        .pred_taken  (pred_taken_s),
        .pred_target (pred_target_s),
        .upd_valid   (btb_upd_valid_i),
        .upd_pc      (btb_upd_pc_i),
        .upd_target  (btb_upd_target_i),
        .upd_taken   (btb_upd_taken_i)
    );

    assign pc_o          = pc_r;
    assign pc_valid_o    = pc_valid_r;
    assign pred_taken_o  = pred_taken_s;
    assign pred_target_o = pred_target_s;

    assign adv_s = pc_valid_r & pc_ready_i & ~stall;

    // Fixed-priority pick among this cycle's sources; scanning downward lets index 0 win.
    always_comb begin
        cur_valid_s  = 1'b0;
        cur_idx_s    = {RIW{1'b0}};
        cur_target_s = {ADDR_WIDTH{1'b0}};
        for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
            cur_valid_s  = cur_valid_s | redir_valid_i[k];
            cur_idx_s    = redir_valid_i[k] ? RIW'(k) : cur_idx_s;
            cur_target_s = redir_valid_i[k] ? redir_target_i[k*ADDR_WIDTH +: ADDR_WIDTH]
                                            : cur_target_s;
        end
    end

    // The buffered entry only beats a live one of strictly higher priority; ties go live.
    assign pend_wins_s  = pend_valid_r & (~cur_valid_s | (pend_idx_r < cur_idx_s));
    assign win_valid_s  = cur_valid_s | pend_valid_r;
    assign win_idx_s    = pend_wins_s ? pend_idx_r    : cur_idx_s;
    assign win_target_s = pend_wins_s ? pend_target_r : cur_target_s;

    // Next fetch address: redirect, then prediction, then sequential.
    always_comb begin
        pc_next_s = pc_r + PC_INC;
        if (win_valid_s) begin
            pc_next_s = win_target_s;
        end else if (pred_taken_s) begin
            pc_next_s = pred_target_s;
        end else begin
            pc_next_s = pc_r + PC_INC;
        end
    end

    // PC, request-valid and pending-redirect state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_VECTOR;
            pc_valid_r    <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_idx_r    <= {RIW{1'b0}};
            pend_target_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            pc_valid_r <= 1'b1;
            if (adv_s) begin
                pc_r         <= pc_next_s;
                pend_valid_r <= 1'b0;
            end else if (cur_valid_s) begin
                pend_valid_r  <= 1'b1;
                pend_idx_r    <= win_idx_s;
                pend_target_r <= win_target_s;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequencing, redirect priority/buffering,
// handshake hold, BTB training and aliasing, wrap-around and mid-run reset.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  redir_valid;
    logic [63:0] redir_target;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    logic [31:0] pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic [31:0] w_pc;
    logic        w_pc_valid;
    logic        w_pred_taken;
    logic [31:0] w_pred_target;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000),
        .NUM_REDIRECT (2),
        .BTB_ENTRIES  (8)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redir_valid_i    (redir_valid),
        .redir_target_i   (redir_target),
        .pc_o             (pc),
        .pc_valid_o       (pc_valid),
        .pc_ready_i       (ready),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .btb_upd_valid_i  (upd_valid),
        .btb_upd_pc_i     (upd_pc),
        .btb_upd_target_i (upd_target),
        .btb_upd_taken_i  (upd_taken)
    );

    pc_gen #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'hFFFF_FFFC),
        .NUM_REDIRECT (2),
        .BTB_ENTRIES  (8)
    ) u_wrap (
        .clk              (clk),
        .rst              (rst),
        .stall            (1'b0),
        .redir_valid_i    (2'b00),
        .redir_target_i   (64'h0),
        .pc_o             (w_pc),
        .pc_valid_o       (w_pc_valid),
        .pc_ready_i       (1'b1),
        .pred_taken_o     (w_pred_taken),
        .pred_target_o    (w_pred_target),
        .btb_upd_valid_i  (1'b0),
        .btb_upd_pc_i     (32'h0),
        .btb_upd_target_i (32'h0),
        .btb_upd_taken_i  (1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1);
        redir_valid  = v;
        redir_target = {t1, t0};
    endtask

    task automatic btb_upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ready = 1'b1;
        redir(2'b00, 32'h0, 32'h0);
        upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;

        // reset and sequential fetch
        tick(); tick();
        chk("rst_valid", {31'h0, pc_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        rst = 1'b0;
        tick();
        chk("rel_valid", {31'h0, pc_valid}, 32'h1);
        chk("seq0", pc, 32'h0);
        chk("wrap0", w_pc, 32'hFFFF_FFFC);
        tick();
        chk("seq4", pc, 32'h4);
        chk("wrap1", w_pc, 32'h0);
        tick();
        chk("seq8", pc, 32'h8);
        tick();
        chk("seqC", pc, 32'hC);

        // simultaneous redirects: index 0 wins
        redir(2'b11, 32'h100, 32'h200);
        tick();
        chk("prio_same", pc, 32'h100);
        redir(2'b00, 32'h0, 32'h0);

        // buffered during stall, higher priority replaces pending
        stall = 1'b1;
        redir(2'b10, 32'h0, 32'h200);
        tick();
        chk("stall_hold1", pc, 32'h100);
        redir(2'b01, 32'h300, 32'h0);
        tick();
        chk("stall_hold2", pc, 32'h100);
        redir(2'b00, 32'h0, 32'h0);
        stall = 1'b0;
        tick();
        chk("pend_hi", pc, 32'h300);
        tick();
        chk("pend_seq", pc, 32'h304);

        // lower priority must not displace pending
        stall = 1'b1;
        redir(2'b01, 32'h600, 32'h0);
        tick();
        redir(2'b10, 32'h0, 32'h700);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        stall = 1'b0;
        tick();
        chk("pend_keep", pc, 32'h600);
        tick();
        chk("pend_keep_seq", pc, 32'h604);

        // handshake hold
        ready = 1'b0;
        redir(2'b10, 32'h0, 32'h40);
        tick();
        chk("hs_hold1", pc, 32'h604);
        redir(2'b00, 32'h0, 32'h0);
        tick();
        chk("hs_hold2", pc, 32'h604);
        tick();
        chk("hs_hold3", pc, 32'h604);
        ready = 1'b1;
        tick();
        chk("hs_release", pc, 32'h40);

        // BTB allocate on taken
        stall = 1'b1;
        btb_upd(32'h20, 32'h80, 1'b1);
        tick();
        upd_valid = 1'b0;
        stall = 1'b0;
        redir(2'b01, 32'h20, 32'h0);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        chk("btb_pc", pc, 32'h20);
        chk("btb_taken", {31'h0, pred_taken}, 32'h1);
        chk("btb_target", pred_target, 32'h80);
        tick();
        chk("btb_follow", pc, 32'h80);

        // alias: same index, different tag
        redir(2'b01, 32'h40, 32'h0);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        chk("alias_pc", pc, 32'h40);
        chk("alias_taken", {31'h0, pred_taken}, 32'h0);
        tick();
        chk("alias_seq", pc, 32'h44);

        // two not-taken updates: WT -> WNT -> SNT
        stall = 1'b1;
        btb_upd(32'h20, 32'h80, 1'b0);
        tick(); tick();
        upd_valid = 1'b0;
        stall = 1'b0;
        redir(2'b01, 32'h20, 32'h0);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        chk("nt_pc", pc, 32'h20);
        chk("nt_taken", {31'h0, pred_taken}, 32'h0);
        tick();
        chk("nt_seq", pc, 32'h24);

        // retrain SNT -> WNT -> WT, park a pending redirect, then reset
        stall = 1'b1;
        btb_upd(32'h20, 32'h90, 1'b1);
        tick(); tick();
        upd_valid = 1'b0;
        redir(2'b10, 32'h0, 32'h500);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        chk("pre_rst_pc", pc, 32'h24);
        rst = 1'b1;
        stall = 1'b0;
        tick(); tick();
        chk("mid_rst_valid", {31'h0, pc_valid}, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst0", pc, 32'h0);
        tick();
        chk("post_rst4", pc, 32'h4);
        redir(2'b01, 32'h20, 32'h0);
        tick();
        redir(2'b00, 32'h0, 32'h0);
        chk("post_rst_at20", pc, 32'h20);
        chk("post_rst_nopred", {31'h0, pred_taken}, 32'h0);
        tick();
        chk("post_rst_seq", pc, 32'h24);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
